// File: rtl/wb_dvp_pkg.sv
// Shared definitions for the Wishbone DVP transmitter: register map, bit positions,
// FSM state encoding and the test-pattern pixel function.
package wb_dvp_pkg;

  localparam logic [3:0] ADR_CTRL   = 4'h0;
  localparam logic [3:0] ADR_STATUS = 4'h4;
  localparam logic [3:0] ADR_DATA   = 4'h8;
  localparam logic [3:0] ADR_POS    = 4'hC;

  localparam int CTRL_START   = 0;
  localparam int CTRL_BUSY    = 0;
  localparam int CTRL_PATTERN = 1;

  localparam int STS_FULL      = 0;
  localparam int STS_EMPTY     = 1;
  localparam int STS_UNDERRUN  = 2;
  localparam int STS_FDONE     = 3;
  localparam int STS_OVERFLOW  = 4;
  localparam int STS_LEVEL_LSB = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_LINE   = 3'd3,
    S_HBLANK = 3'd4,
    S_DONE   = 3'd5
  } dvp_state_e;

  function automatic logic [7:0] pattern_pixel(input logic [15:0] pix, input logic [15:0] line);
    return pix[7:0] ^ line[7:0];
  endfunction

endpackage

// File: rtl/dvp_tx_fifo.sv
// Pixel FIFO: registered storage with a combinational read of the head entry.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module dvp_tx_fifo
  import wb_dvp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [LW-1:0] level_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign dout_o    = mem_q[rptr_q];
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push_s) wptr_q <= wptr_q + AW'(1);
      if (do_pop_s)  rptr_q <= rptr_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_dvp_tx.sv
// Wishbone-controlled DVP transmitter: replays FIFO bytes (or an XOR test pattern)
// as a camera-style vsync/href/data stream clocked by a divided pixel clock.
module wb_dvp_tx
  import wb_dvp_pkg::*;
#(
  parameter int H_ACTIVE   = 160,
  parameter int V_ACTIVE   = 120,
  parameter int H_BLANK    = 16,
  parameter int VSYNC_LEN  = 8,
  parameter int V_BACK     = 8,
  parameter int PCLK_HALF  = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        dvp_pclk,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d, rdata_s;
  logic             pat_q, pat_d;
  logic             under_q, under_d, fdone_q, fdone_d, ovf_q, ovf_d;
  logic             pclk_q;
  logic [DIV_W-1:0] div_q;
  dvp_state_e       state_q, state_d;
  logic [15:0]      ph_q, ph_d, pix_q, pix_d, line_q, line_d;
  logic             vsync_q, vsync_d, href_q, href_d;
  logic [7:0]       data_q, data_d;
  logic             armed_q, armed_d, pat_act_q, pat_act_d;
  logic             req_s, wr_s, wr_ctrl_s, wr_status_s, push_s, start_s, busy_s, tick_s;
  logic             emit_s, pop_s, under_set_s, fdone_set_s, ovf_set_s;
  logic [7:0]       fifo_dout_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [LVL_W-1:0] fifo_level_s;
  logic             unused_s;

  assign unused_s    = ^{wb_sel_i, wb_adr_i[31:4], wb_dat_i[31:8]};
  assign req_s       = wb_stb_i & wb_cyc_i;
  assign wr_s        = req_s & ack_q & wb_we_i;
  assign wr_ctrl_s   = wr_s && (wb_adr_i[3:0] == ADR_CTRL);
  assign wr_status_s = wr_s && (wb_adr_i[3:0] == ADR_STATUS);
  assign push_s      = wr_s && (wb_adr_i[3:0] == ADR_DATA);
  assign start_s     = wr_ctrl_s & wb_dat_i[CTRL_START];
  assign busy_s      = (state_q != S_IDLE) | armed_q;
  assign tick_s      = pclk_q && (div_q == DIV_W'(PCLK_HALF - 1));
  assign ovf_set_s   = push_s & fifo_full_s & ~pop_s;

  assign wb_ack_o  = req_s & ack_q;
  assign wb_dat_o  = dat_q;
  assign dvp_pclk  = pclk_q;
  assign dvp_vsync = vsync_q;
  assign dvp_href  = href_q;
  assign dvp_data  = data_q;

  dvp_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .din_i   (wb_dat_i[7:0]),
    .pop_i   (pop_s),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level_s)
  );

  // Read data is captured in the request cycle so it is presented exactly with ack.
  always_comb begin
    rdata_s = 32'h0;
    case (wb_adr_i[3:0])
      ADR_CTRL: begin
        rdata_s[CTRL_BUSY]    = busy_s;
        rdata_s[CTRL_PATTERN] = pat_q;
      end
      ADR_STATUS: begin
        rdata_s[STS_FULL]     = fifo_full_s;
        rdata_s[STS_EMPTY]    = fifo_empty_s;
        rdata_s[STS_UNDERRUN] = under_q;
        rdata_s[STS_FDONE]    = fdone_q;
        rdata_s[STS_OVERFLOW] = ovf_q;
        rdata_s[STS_LEVEL_LSB +: 8] = 8'(fifo_level_s);
      end
      ADR_POS: rdata_s = {line_q, pix_q};
      default: rdata_s = 32'h0;
    endcase
    ack_d   = req_s & ~ack_q;
    dat_d   = (req_s & ~ack_q & ~wb_we_i) ? rdata_s : 32'h0;
    pat_d   = wr_ctrl_s ? wb_dat_i[CTRL_PATTERN] : pat_q;
    under_d = under_set_s | (under_q & ~(wr_status_s & wb_dat_i[STS_UNDERRUN]));
    fdone_d = fdone_set_s | (fdone_q & ~(wr_status_s & wb_dat_i[STS_FDONE]));
    ovf_d   = ovf_set_s | (ovf_q & ~(wr_status_s & wb_dat_i[STS_OVERFLOW]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'h0;
      pat_q   <= 1'b0;
      under_q <= 1'b0;
      fdone_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      pat_q   <= pat_d;
      under_q <= under_d;
      fdone_q <= fdone_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pclk_q <= 1'b0;
      div_q  <= '0;
    end else if (div_q == DIV_W'(PCLK_HALF - 1)) begin
      pclk_q <= ~pclk_q;
      div_q  <= '0;
    end else begin
      div_q  <= div_q + DIV_W'(1);
    end
  end

  // Frame sequencer: everything advances only on a pixel tick (pclk falling).
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    pix_d       = pix_q;
    line_d      = line_q;
    vsync_d     = vsync_q;
    href_d      = href_q;
    data_d      = data_q;
    armed_d     = armed_q;
    pat_act_d   = pat_act_q;
    emit_s      = 1'b0;
    fdone_set_s = 1'b0;
    if (start_s && !busy_s) begin
      armed_d   = 1'b1;
      pat_act_d = wb_dat_i[CTRL_PATTERN];
    end else begin
      armed_d   = armed_q;
    end
    if (tick_s) begin
      case (state_q)
        S_IDLE: begin
          if (armed_q) begin
            state_d = S_VSYNC;
            vsync_d = 1'b1;
            ph_d    = 16'd0;
            armed_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_VSYNC: begin
          if (ph_q == 16'(VSYNC_LEN - 1)) begin
            state_d = S_VBACK;
            vsync_d = 1'b0;
            ph_d    = 16'd0;
          end else begin
            ph_d    = ph_q + 16'd1;
          end
        end
        S_VBACK: begin
          if (ph_q == 16'(V_BACK - 1)) begin
            state_d = S_LINE;
            pix_d   = 16'd0;
            line_d  = 16'd0;
            emit_s  = 1'b1;
          end else begin
            ph_d    = ph_q + 16'd1;
          end
        end
        S_LINE: begin
          if (pix_q == 16'(H_ACTIVE - 1)) begin
            state_d = S_HBLANK;
            href_d  = 1'b0;
            data_d  = 8'h00;
            ph_d    = 16'd0;
          end else begin
            pix_d   = pix_q + 16'd1;
            emit_s  = 1'b1;
          end
        end
        S_HBLANK: begin
          if (ph_q != 16'(H_BLANK - 1)) begin
            ph_d    = ph_q + 16'd1;
          end else if (line_q == 16'(V_ACTIVE - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LINE;
            line_d  = line_q + 16'd1;
            pix_d   = 16'd0;
            emit_s  = 1'b1;
          end
        end
        S_DONE: begin
          state_d     = S_IDLE;
          fdone_set_s = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          vsync_d = 1'b0;
          href_d  = 1'b0;
          data_d  = 8'h00;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    pop_s       = emit_s & ~pat_act_q;
    under_set_s = emit_s & ~pat_act_q & fifo_empty_s;
    if (emit_s) begin
      href_d = 1'b1;
      data_d = pat_act_q ? pattern_pixel(pix_d, line_d) : (fifo_empty_s ? 8'h00 : fifo_dout_s);
    end else begin
      href_d = href_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ph_q      <= 16'd0;
      pix_q     <= 16'd0;
      line_q    <= 16'd0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      data_q    <= 8'h00;
      armed_q   <= 1'b0;
      pat_act_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      pix_q     <= pix_d;
      line_q    <= line_d;
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      data_q    <= data_d;
      armed_q   <= armed_d;
      pat_act_q <= pat_act_d;
    end
  end

endmodule
